// File: rtl/scatter_stream_if.sv
// Batch-in / sparse-lanes-out bus for scatter_stream.
// The slave modport is the scatter block; the master modport is the producer/lane-array side.
interface scatter_stream_if #(
  parameter int unsigned DATA = 32,
  parameter int unsigned IN   = 8,
  parameter int unsigned OUT  = 8
);
  localparam int unsigned CNT = $clog2(IN) + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [CNT-1:0]            in_cnt;
  logic [IN-1:0][DATA-1:0]   in;
  logic [OUT-1:0]            sel;
  logic [OUT-1:0]            out_valid;
  logic [OUT-1:0][DATA-1:0]  out;
  logic [CNT-1:0]            out_cnt;
  logic                      busy;

  modport slave (
    input  in_valid, in_cnt, in, sel,
    output in_ready, out_valid, out, out_cnt, busy
  );

  modport master (
    output in_valid, in_cnt, in, sel,
    input  in_ready, out_valid, out, out_cnt, busy
  );
endinterface

// File: rtl/scatter_stream.sv
// Registered scatter: holds one packed batch and drains it in order onto the lanes offered by sel.
// Optional SCATTER_STREAM_ROTATE_EN starts each scan after the last lane used, spreading load across lanes.
module scatter_stream #(
  parameter int unsigned DATA = 32,
  parameter int unsigned IN   = 8,
  parameter int unsigned OUT  = 8,
  parameter bit          ACT  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              flush,
  scatter_stream_if.slave   bus
);
  localparam int unsigned CNT     = $clog2(IN) + 1;
  localparam int unsigned IW      = (IN > 1) ? $clog2(IN) : 1;
  localparam int unsigned LW      = (OUT > 1) ? $clog2(OUT) : 1;
  localparam logic        ENABLE  = ACT;
  localparam logic        DISABLE = ~ACT;

  logic [IN-1:0][DATA-1:0]  data_q, data_d;
  logic [CNT-1:0]           cnt_q, cnt_d;
  logic [CNT-1:0]           ptr_q, ptr_d;
  logic [OUT-1:0][DATA-1:0] out_q, out_d;
  logic [OUT-1:0]           out_valid_q, out_valid_d;
  logic [CNT-1:0]           out_cnt_q, out_cnt_d;
  logic                     busy_q, busy_d;

  logic [CNT-1:0]           rem;
  logic [CNT-1:0]           take;
  logic [CNT-1:0]           idx;
  logic [LW-1:0]            lane;
  logic [OUT-1:0][DATA-1:0] asg_out;
  logic [OUT-1:0]           asg_valid;
  logic                     accept;

`ifdef SCATTER_STREAM_ROTATE_EN
  logic [LW-1:0]            lp_q, lp_d;
  logic [LW-1:0]            last;
`endif

  // Lane assignment: k-th enabled lane in scan order gets element ptr+k, up to rem lanes.
  always_comb begin
    rem       = cnt_q - ptr_q;
    take      = '0;
    idx       = '0;
    lane      = '0;
    asg_out   = '0;
    asg_valid = {OUT{DISABLE}};
`ifdef SCATTER_STREAM_ROTATE_EN
    last      = '0;
`endif
    for (int i = 0; i < int'(OUT); i++) begin
`ifdef SCATTER_STREAM_ROTATE_EN
      lane = LW'((int'(lp_q) + i) % int'(OUT));
`else
      lane = LW'(i);
`endif
      if (bus.sel[lane] == ENABLE && take < rem) begin
        idx             = ptr_q + take;
        asg_out[lane]   = data_q[IW'(idx)];
        asg_valid[lane] = ENABLE;
`ifdef SCATTER_STREAM_ROTATE_EN
        last            = lane;
`endif
        take            = take + CNT'(1);
      end
    end
  end

  // A new batch may land in the same cycle the old one finishes draining.
  assign bus.in_ready = !flush && (rem == '0 || take == rem);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    data_d      = data_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q + take;
    out_d       = asg_out;
    out_valid_d = asg_valid;
    out_cnt_d   = take;
`ifdef SCATTER_STREAM_ROTATE_EN
    lp_d        = (take != '0) ? LW'((int'(last) + 1) % int'(OUT)) : lp_q;
`endif
    if (accept) begin
      data_d = bus.in;
      cnt_d  = (bus.in_cnt > CNT'(IN)) ? CNT'(IN) : bus.in_cnt;
      ptr_d  = '0;
    end
    // Flush wins over both accept and consume.
    if (flush) begin
      cnt_d       = '0;
      ptr_d       = '0;
      out_d       = '0;
      out_valid_d = {OUT{DISABLE}};
      out_cnt_d   = '0;
`ifdef SCATTER_STREAM_ROTATE_EN
      lp_d        = '0;
`endif
    end
    busy_d = (cnt_d != ptr_d);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      data_q      <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= {OUT{DISABLE}};
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
`ifdef SCATTER_STREAM_ROTATE_EN
      lp_q        <= '0;
`endif
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
`ifdef SCATTER_STREAM_ROTATE_EN
      lp_q        <= lp_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.busy      = busy_q;
endmodule
